// File: rtl/i2c_target_rx.sv
// I2C target write receiver: address match, per-byte ACK/NAK and a one-cycle byte strobe.
// Define I2C_GENERAL_CALL_EN to also accept the general-call address (0x00) and expose gcall.
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  input  logic       rx_ready,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       busy,
  output logic       addr_match,
  output logic       stop_det
`ifdef I2C_GENERAL_CALL_EN
  ,
  output logic       gcall
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_ST  = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_evt;
  logic                   stop_evt;

  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        byte_done_reg, byte_done_next;
  logic        sda_oe_reg, sda_oe_next;
  logic [7:0]  data_reg, data_next;
  logic        data_valid_reg, data_valid_next;
  logic        busy_reg, busy_next;
  logic        addr_match_reg, addr_match_next;
  logic        stop_det_reg, stop_det_next;
  logic        addr_hit;
  logic        gc_hit;
`ifdef I2C_GENERAL_CALL_EN
  logic        gcall_reg, gcall_next;
`endif

  // Bus idles high, so the synchronisers reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda};
      scl_d_reg    <= scl_s;
      sda_d_reg    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  assign start_evt = scl_s & sda_d_reg & ~sda_s;
  assign stop_evt  = scl_s & ~sda_d_reg & sda_s;

  assign addr_hit = (shift_reg[7:1] == ADDR) && !shift_reg[0];
`ifdef I2C_GENERAL_CALL_EN
  assign gc_hit = (shift_reg == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      byte_done_reg  <= 1'b0;
      sda_oe_reg     <= 1'b0;
      data_reg       <= 8'h00;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      addr_match_reg <= 1'b0;
      stop_det_reg   <= 1'b0;
`ifdef I2C_GENERAL_CALL_EN
      gcall_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      byte_done_reg  <= byte_done_next;
      sda_oe_reg     <= sda_oe_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      busy_reg       <= busy_next;
      addr_match_reg <= addr_match_next;
      stop_det_reg   <= stop_det_next;
`ifdef I2C_GENERAL_CALL_EN
      gcall_reg      <= gcall_next;
`endif
    end
  end

  // Byte-level decisions are taken on the SCL fall after the 8th bit, so SDA only moves while SCL is low.
  always_comb begin
    state_next = state_reg;
    if (stop_evt) begin
      state_next = IDLE;
    end else if (start_evt) begin
      state_next = ADDR_ST;
    end else if (scl_fall) begin
      case (state_reg)
        ADDR_ST:  if (byte_done_reg) state_next = (addr_hit || gc_hit) ? ADDR_ACK : IGNORE;
        ADDR_ACK: state_next = DATA;
        DATA:     if (byte_done_reg) state_next = rx_ready ? DATA_ACK : IGNORE;
        DATA_ACK: state_next = DATA;
        default:  state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    byte_done_next  = byte_done_reg;
    sda_oe_next     = sda_oe_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    busy_next       = busy_reg;
    addr_match_next = addr_match_reg;
    stop_det_next   = 1'b0;
`ifdef I2C_GENERAL_CALL_EN
    gcall_next      = gcall_reg;
`endif
    if (stop_evt) begin
      sda_oe_next     = 1'b0;
      busy_next       = 1'b0;
      addr_match_next = 1'b0;
      stop_det_next   = busy_reg;
      bit_cnt_next    = 3'd0;
      byte_done_next  = 1'b0;
`ifdef I2C_GENERAL_CALL_EN
      gcall_next      = 1'b0;
`endif
    end else if (start_evt) begin
      sda_oe_next     = 1'b0;
      busy_next       = 1'b1;
      addr_match_next = 1'b0;
      bit_cnt_next    = 3'd0;
      byte_done_next  = 1'b0;
`ifdef I2C_GENERAL_CALL_EN
      gcall_next      = 1'b0;
`endif
    end else begin
      if (scl_rise && (state_reg == ADDR_ST || state_reg == DATA) && !byte_done_reg) begin
        shift_next   = {shift_reg[6:0], sda_s};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) byte_done_next = 1'b1;
      end
      if (scl_fall) begin
        case (state_reg)
          ADDR_ST: begin
            if (byte_done_reg) begin
              byte_done_next = 1'b0;
              if (addr_hit || gc_hit) begin
                sda_oe_next     = 1'b1;
                addr_match_next = 1'b1;
`ifdef I2C_GENERAL_CALL_EN
                gcall_next      = gc_hit;
`endif
              end
            end
          end
          DATA: begin
            if (byte_done_reg) begin
              byte_done_next = 1'b0;
              if (rx_ready) begin
                data_next       = shift_reg;
                data_valid_next = 1'b1;
                sda_oe_next     = 1'b1;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 3'd0;
          end
          default: sda_oe_next = 1'b0;
        endcase
      end
    end
  end

  assign sda_oe     = sda_oe_reg;
  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign busy       = busy_reg;
  assign addr_match = addr_match_reg;
  assign stop_det   = stop_det_reg;
`ifdef I2C_GENERAL_CALL_EN
  assign gcall      = gcall_reg;
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: acts as the I2C controller on a wired-AND SDA line and
// checks ACKs, received bytes, strobes and bus-state outputs against a transaction-level model.
module tb_i2c_target_rx;
  localparam int Q = 10;
`ifdef I2C_GENERAL_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       addr_match;
  logic       stop_det;
`ifdef I2C_GENERAL_CALL_EN
  logic       gcall;
`endif

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int sd_cnt = 0;
  int busy_drops = 0;
  bit busy_watch = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_rx #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rstn(rstn),
    .scl(scl_m),
    .sda(sda_line),
    .sda_oe(sda_oe),
    .rx_ready(rx_ready),
    .data(data),
    .data_valid(data_valid),
    .busy(busy),
    .addr_match(addr_match),
    .stop_det(stop_det)
`ifdef I2C_GENERAL_CALL_EN
    ,
    .gcall(gcall)
`endif
  );

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      got_q.push_back(data);
    end
    if (stop_det) sd_cnt++;
    if (busy_watch && !busy) busy_drops++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  // viol reports the target driving SDA during a controller-owned bit
  task automatic write_bit(input bit b, output bit viol);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    viol = sda_oe || (sda_line !== b);
    wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack, output bit viol);
    bit v;
    viol = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      write_bit(b[i], v);
      viol = viol | v;
    end
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    ack = (sda_line === 1'b0);
    wq();
    scl_m = 1'b0; wq();
  endtask

  // Model: address ACK iff 7'h42+W (or general call when enabled); each data byte ACKed iff
  // still accepting and rx_ready; the first NAK ends acceptance until STOP.
  task automatic txn(input logic [7:0] ab, input int n, input logic [31:0] dbytes, input logic [3:0] rdy);
    bit ack, viol, exp_ack, accepting;
    int dv0, sd0, nacks;
    logic [7:0] d;
    dv0 = dv_cnt;
    sd0 = sd_cnt;
    nacks = 0;
    exp_q.delete();
    got_q.delete();
    exp_ack = ((ab >> 1) == 8'h42 && ab[0] == 1'b0) || (GC && ab == 8'h00);
    i2c_start();
    chk("busy_start", 32'(busy), 32'(1));
    write_byte(ab, ack, viol);
    chk("addr_ack", 32'(ack), 32'(exp_ack));
    chk("addr_drive", 32'(viol), 32'(0));
    chk("addr_match", 32'(addr_match), 32'(exp_ack));
`ifdef I2C_GENERAL_CALL_EN
    chk("gcall", 32'(gcall), 32'(exp_ack && ab == 8'h00));
`endif
    accepting = exp_ack;
    for (int i = 0; i < n; i++) begin
      d = dbytes[8*i +: 8];
      rx_ready = rdy[i];
      write_byte(d, ack, viol);
      chk("data_ack", 32'(ack), 32'(accepting && rdy[i]));
      chk("data_drive", 32'(viol), 32'(0));
      if (accepting && rdy[i]) begin
        exp_q.push_back(d);
        nacks++;
      end else begin
        accepting = 1'b0;
      end
    end
    rx_ready = 1'b1;
    chk("busy_hold", 32'(busy), 32'(1));
    i2c_stop();
    chk("dv_count", 32'(dv_cnt - dv0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("data_seq", 32'(got_q[i]), 32'(exp_q[i]));
    if (exp_q.size() > 0) chk("data_out", 32'(data), 32'(exp_q[$]));
    chk("stop_det", 32'(sd_cnt - sd0), 32'(1));
    chk("busy_stop", 32'(busy), 32'(0));
    chk("am_stop", 32'(addr_match), 32'(0));
    $display("txn addr=%02h bytes=%0d data=%08h rdy=%b addr_ack=%0d acked_bytes=%0d strobes=%0d",
             ab, n, dbytes, rdy, exp_ack, nacks, dv_cnt - dv0);
  endtask

  initial begin
    bit ack, viol;
    int dv0, sd0;
    logic [7:0] ab;

    repeat (5) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_dv", 32'(data_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_am", 32'(addr_match), 32'(0));
    chk("rst_stop", 32'(stop_det), 32'(0));
    rstn = 1'b1;
    wq();

    txn(8'h84, 1, 32'h000000AA, 4'hF);
    txn(8'h86, 1, 32'h00000055, 4'hF);
    txn(8'h84, 3, 32'h0033F055, 4'b1101);
    txn(8'h85, 1, 32'h00000011, 4'hF);

    // partial byte abandoned by a repeated START
    dv0 = dv_cnt;
    sd0 = sd_cnt;
    got_q.delete();
    busy_drops = 0;
    i2c_start();
    busy_watch = 1'b1;
    write_byte(8'h84, ack, viol);
    chk("rs_addr1_ack", 32'(ack), 32'(1));
    write_bit(1'b1, viol);
    write_bit(1'b0, viol);
    write_bit(1'b1, viol);
    i2c_start();
    chk("rs_am_clear", 32'(addr_match), 32'(0));
    write_byte(8'h84, ack, viol);
    chk("rs_addr2_ack", 32'(ack), 32'(1));
    write_byte(8'h0F, ack, viol);
    chk("rs_data_ack", 32'(ack), 32'(1));
    busy_watch = 1'b0;
    i2c_stop();
    chk("rs_dv_count", 32'(dv_cnt - dv0), 32'(1));
    if (got_q.size() > 0) chk("rs_data", 32'(got_q[0]), 32'(8'h0F));
    chk("rs_busy_drops", 32'(busy_drops), 32'(0));
    chk("rs_stop_det", 32'(sd_cnt - sd0), 32'(1));
    $display("txn repeated-start addr=84 partial=3b then addr=84 data=0F strobes=%0d", dv_cnt - dv0);

    // asynchronous reset while the target is ACKing a data byte
    i2c_start();
    write_byte(8'h84, ack, viol);
    for (int i = 7; i >= 0; i--) write_bit(1'b1, viol);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    chk("ack_before_rst", 32'(sda_oe), 32'(1));
    #2 rstn = 1'b0;
    #1;
    chk("arst_sda_oe", 32'(sda_oe), 32'(0));
    chk("arst_data", 32'(data), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_am", 32'(addr_match), 32'(0));
    chk("arst_dv", 32'(data_valid), 32'(0));
    $display("txn reset during data ACK sda_oe=%0d busy=%0d", sda_oe, busy);
    wq();
    rstn = 1'b1;
    wq();
    txn(8'h84, 1, 32'h00000033, 4'hF);

    txn(8'h00, 1, 32'h00000022, 4'hF);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: ab = 8'h84;
        1: ab = 8'h85;
        2: ab = 8'h86;
        default: ab = 8'($urandom);
      endcase
      txn(ab, int'($urandom_range(1, 3)), $urandom, 4'($urandom) | 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
